pcx_fifo_arb: RTL and testbench
===============================

// Module: pcx_fifo_arb
// PURPOSE
//  Round-robin write-side arbiter sharing one pcx_fifo between N_REQ PCX packet sources.
//  Tracks FIFO occupancy internally (write grants minus FIFO reads) and keeps the two
//  beats of an atomic (CAS) packet contiguous. Both beats are admitted only with 2 free slots.
//  Sits between the requesters and pcx_fifo wrreq/data; monitors the FIFO's rdreq.
// PARAMETERS
//  DATA_WIDTH  130  PCX packet width
//  N_REQ       2    number of requesters (2..4)
//  FIFO_DEPTH  32   entries in the downstream pcx_fifo
//  CNT_WIDTH   6    occupancy counter width; holds 0..FIFO_DEPTH
// PORTS
//  clock      in   1               clock, all logic on posedge
//  aclr       in   1               reset, synchronous, active-high
//  req_valid  in   N_REQ           requester i has a packet beat on req_data
//  req_atomic in   N_REQ           beat is first of a 2-beat atomic; sampled only in IDLE
//  req_data   in   N_REQ*DATA_WIDTH beat data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//  req_grant  out  N_REQ           one-hot; beat of requester i consumed this cycle
//  fifo_wrreq out  1               to pcx_fifo wrreq; equals |req_grant
//  fifo_data  out  DATA_WIDTH      to pcx_fifo data; req_data of the granted requester, else 0
//  fifo_rdreq in   1               copy of pcx_fifo rdreq, used for occupancy tracking
//  occupancy  out  CNT_WIDTH       current FIFO entry count (registered)
//  arb_locked out  1               1 while waiting for an atomic second beat (registered)
// BEHAVIOUR
//  Reset, aclr=1 at posedge:
//   - state=IDLE, occupancy=0, arb_locked=0.
//   - last_grant=N_REQ-1, so requester 0 has top priority first.
//   - Grants are combinational and are also forced to 0 while aclr=1.
//   - aclr is asserted together with the pcx_fifo clear; mid-atomic reset discards the lock.
//  free = FIFO_DEPTH - occupancy.
//  IDLE:
//   - Winner = first valid requester scanning last_grant+1, +2, ... (mod N_REQ).
//   - Winner needs free>=2 if req_atomic, else free>=1. If short of space, no grant this cycle.
//   - The winner is never bypassed for a lower-priority fitting requester (no starvation).
//   - On grant: req_grant[w]=1, fifo_wrreq=1, fifo_data=req_data[w], last_grant<=w.
//   - If the granted beat is atomic: owner<=w, state<=LOCKED.
//  LOCKED:
//   - Only owner is eligible; grant when req_valid[owner] (space guaranteed by reservation).
//   - req_atomic is ignored. On grant, state<=IDLE; last_grant stays unchanged.
//   - If owner holds valid low, wait indefinitely; other requesters get no grant.
//  Latency: a beat is granted in the cycle it is valid and arbitration and space allow.
//   fifo_wrreq is zero-latency combinational; no registered data path.
//  Occupancy: occ_next = occ + fifo_wrreq - (fifo_rdreq && occ!=0).
//   - Simultaneous write and read leaves occupancy unchanged.
//   - A read at occ==0 is ignored.
//   - occupancy never exceeds FIFO_DEPTH; a write at full is impossible by construction.
//  arb_locked = (state==LOCKED).
// TESTING
//  1 After reset, req_valid=2'b11, non-atomic, every cycle:
//    -> grants alternate 01,10,01,..., starting with req 0; occupancy +1 per cycle.
//  2 occupancy=31, req0 atomic valid, no reads:
//    -> no grant. Assert fifo_rdreq for one cycle -> occ 30, grant req0 next cycle, occ 31.
//  3 req0 atomic beat granted, req0 valid dropped 3 cycles, req1 valid throughout:
//    -> req1 gets no grant; arb_locked=1; req0 second beat granted, then req1 next cycle.
//  4 occ=32 with fifo_rdreq and a req_valid in the same cycle:
//    -> no write (free=0), occ 31. With occ=10, write and read together -> occ stays 10.
//  5 aclr pulsed while LOCKED with occ=7:
//    -> next cycle state IDLE, occ 0, arb_locked 0, req0 has top priority.
//  6 N_REQ=4, all valid, req2 atomic:
//    -> order 0,1,2,2(second beat),3,0; fifo_data matches the granted source each cycle.

Source files
------------

// File: rtl/pcx_fifo_arb.sv
// pcx_fifo_arb: round-robin write arbiter for a shared pcx_fifo with occupancy tracking and atomic beat pairing
module pcx_fifo_arb #(
  parameter int DATA_WIDTH = 130,
  parameter int N_REQ      = 2,
  parameter int FIFO_DEPTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                        clock,
  input  logic                        aclr,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ-1:0]            req_atomic,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            req_grant,
  output logic                        fifo_wrreq,
  output logic [DATA_WIDTH-1:0]       fifo_data,
  input  logic                        fifo_rdreq,
  output logic [CNT_WIDTH-1:0]        occupancy,
  output logic                        arb_locked
);
  localparam int IW = N_REQ > 1 ? $clog2(N_REQ) : 1;
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t               state, state_next;
  logic [IW-1:0]        last_grant, owner, win, sel, idx;
  logic                 found, grant_en;
  logic [CNT_WIDTH:0]   free, need;
  logic [CNT_WIDTH-1:0] occ_next;
  // scan farthest-to-nearest so the closest valid requester after last_grant wins
  always_comb begin
    found = 1'b0;
    win = '0;
    idx = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = IW'((int'(last_grant) + k) % N_REQ);
      if (req_valid[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
    free = (CNT_WIDTH+1)'(FIFO_DEPTH) - {1'b0, occupancy};
    need = req_atomic[win] ? (CNT_WIDTH+1)'(2) : (CNT_WIDTH+1)'(1);
    sel = state == LOCKED ? owner : win;
    grant_en = !aclr && (state == LOCKED ? req_valid[owner] : (found && free >= need));
    req_grant = grant_en ? N_REQ'(1) << sel : '0;
    fifo_data = grant_en ? req_data[sel*DATA_WIDTH +: DATA_WIDTH] : '0;
    state_next = state == IDLE ? ((grant_en && req_atomic[win]) ? LOCKED : IDLE)
                               : (grant_en ? IDLE : LOCKED);
    occ_next = occupancy + CNT_WIDTH'(grant_en) - CNT_WIDTH'(fifo_rdreq && occupancy != '0);
  end
  assign fifo_wrreq = |req_grant;
  assign arb_locked = state == LOCKED;
  always_ff @(posedge clock) begin
    if (aclr) begin
      state <= IDLE;
      occupancy <= '0;
      last_grant <= IW'(N_REQ - 1);
      owner <= '0;
    end else begin
      state <= state_next;
      occupancy <= occ_next;
      if (grant_en && state == IDLE) begin
        last_grant <= win;
        owner <= win;
      end
    end
  end
endmodule

// File: tb/tb_pcx_fifo_arb.sv
// tb_pcx_fifo_arb: directed scenarios plus randomized traffic against a behavioural arbiter model
module tb_pcx_fifo_arb;
  localparam int DW = 130, NR = 4, DEPTH = 32, CW = 6;
  logic              clock = 1'b0;
  logic              aclr;
  logic [NR-1:0]     req_valid, req_atomic, req_grant;
  logic [NR*DW-1:0]  req_data;
  logic              fifo_wrreq, fifo_rdreq, arb_locked;
  logic [DW-1:0]     fifo_data;
  logic [CW-1:0]     occupancy;
  int checks = 0, errors = 0;
  int m_occ = 0, m_last = NR - 1, m_owner = 0, g_w = 0;
  bit m_lock = 1'b0;
  logic [NR-1:0] e_grant;
  logic [DW-1:0] e_data;

  pcx_fifo_arb #(.DATA_WIDTH(DW), .N_REQ(NR), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clock(clock), .aclr(aclr), .req_valid(req_valid), .req_atomic(req_atomic),
    .req_data(req_data), .req_grant(req_grant), .fifo_wrreq(fifo_wrreq),
    .fifo_data(fifo_data), .fifo_rdreq(fifo_rdreq), .occupancy(occupancy),
    .arb_locked(arb_locked));

  always #5 clock = ~clock;

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom, 2'($urandom)};
  endfunction

  task automatic rnd_all_data();
    for (int r = 0; r < NR; r++) req_data[r*DW +: DW] = rnd_data();
  endtask

  // expected grant for the current inputs from the arbitration rules
  function automatic void model_eval();
    int w;
    e_grant = '0;
    e_data = '0;
    w = -1;
    if (aclr) return;
    if (m_lock) begin
      if (!req_valid[m_owner]) return;
      w = m_owner;
    end else begin
      for (int k = 1; k <= NR; k++)
        if (w < 0 && req_valid[(m_last + k) % NR]) w = (m_last + k) % NR;
      if (w < 0) return;
      if (DEPTH - m_occ < (req_atomic[w] ? 2 : 1)) return;
    end
    g_w = w;
    e_grant[w] = 1'b1;
    e_data = req_data[w*DW +: DW];
  endfunction

  function automatic void model_commit();
    int wr;
    if (aclr) begin
      m_occ = 0; m_last = NR - 1; m_lock = 1'b0; m_owner = 0;
      return;
    end
    wr = (e_grant != '0) ? 1 : 0;
    if (wr == 1) begin
      if (m_lock) m_lock = 1'b0;
      else begin
        m_last = g_w;
        if (req_atomic[g_w]) begin m_lock = 1'b1; m_owner = g_w; end
      end
    end
    m_occ = m_occ + wr - ((fifo_rdreq && m_occ > 0) ? 1 : 0);
  endfunction

  task automatic settle();
    @(negedge clock);
    model_eval();
  endtask

  task automatic advance();
    model_commit();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_reset();
    aclr = 1'b1; req_valid = '0; req_atomic = '0; fifo_rdreq = 1'b0;
    settle(); advance();
    aclr = 1'b0;
  endtask

  task automatic test_reset();
    aclr = 1'b1; req_valid = '1; req_atomic = '0; fifo_rdreq = 1'b0; rnd_all_data();
    settle();
    checks++; if (req_grant !== '0 || fifo_wrreq !== 1'b0) begin errors++; $display("FAIL reset_grant got=%b/%b exp=0000/0", req_grant, fifo_wrreq); end
    advance();
    settle();
    checks++; if (occupancy !== '0 || arb_locked !== 1'b0) begin errors++; $display("FAIL reset_state occ=%0d lock=%b exp 0/0", occupancy, arb_locked); end
    advance();
    aclr = 1'b0; req_valid = '0;
  endtask

  task automatic test_alternate();
    req_valid = 4'b0011; req_atomic = '0;
    for (int i = 0; i < 8; i++) begin
      rnd_all_data();
      settle();
      checks++; if (req_grant !== ((i % 2) ? 4'b0010 : 4'b0001)) begin errors++; $display("FAIL alt_grant cyc=%0d got=%b", i, req_grant); end
      checks++; if (occupancy !== CW'(i)) begin errors++; $display("FAIL alt_occ cyc=%0d got=%0d exp=%0d", i, occupancy, i); end
      checks++; if (fifo_data !== req_data[(i % 2)*DW +: DW]) begin errors++; $display("FAIL alt_data cyc=%0d got=%h", i, fifo_data); end
      advance();
    end
  endtask

  task automatic test_full_atomic();
    req_valid = 4'b0001; req_atomic = '0;
    for (int i = 8; i < 31; i++) begin
      settle();
      checks++; if (occupancy !== CW'(i) || req_grant !== 4'b0001) begin errors++; $display("FAIL fill occ=%0d grant=%b exp occ=%0d", occupancy, req_grant, i); end
      advance();
    end
    req_atomic = 4'b0001;
    for (int i = 0; i < 2; i++) begin
      settle();
      checks++; if (req_grant !== '0 || occupancy !== CW'(31)) begin errors++; $display("FAIL atom_nospace grant=%b occ=%0d exp 0000/31", req_grant, occupancy); end
      advance();
    end
    fifo_rdreq = 1'b1;
    settle();
    checks++; if (req_grant !== '0) begin errors++; $display("FAIL atom_rdcycle grant=%b exp=0000", req_grant); end
    advance();
    fifo_rdreq = 1'b0;
    settle();
    checks++; if (occupancy !== CW'(30) || req_grant !== 4'b0001 || arb_locked !== 1'b0) begin errors++; $display("FAIL atom_first occ=%0d grant=%b lock=%b exp 30/0001/0", occupancy, req_grant, arb_locked); end
    advance();
    settle();
    checks++; if (occupancy !== CW'(31) || req_grant !== 4'b0001 || arb_locked !== 1'b1) begin errors++; $display("FAIL atom_second occ=%0d grant=%b lock=%b exp 31/0001/1", occupancy, req_grant, arb_locked); end
    advance();
  endtask

  task automatic test_full_read();
    req_valid = 4'b0010; req_atomic = '0; fifo_rdreq = 1'b1;
    settle();
    checks++; if (occupancy !== CW'(32) || req_grant !== '0) begin errors++; $display("FAIL full_rd occ=%0d grant=%b exp 32/0000", occupancy, req_grant); end
    advance();
    req_valid = '0;
    for (int i = 31; i > 10; i--) begin
      settle();
      checks++; if (occupancy !== CW'(i)) begin errors++; $display("FAIL drain occ=%0d exp=%0d", occupancy, i); end
      advance();
    end
    req_valid = 4'b0001;
    settle();
    checks++; if (req_grant !== 4'b0001 || occupancy !== CW'(10)) begin errors++; $display("FAIL wr_rd grant=%b occ=%0d exp 0001/10", req_grant, occupancy); end
    advance();
    req_valid = '0; fifo_rdreq = 1'b0;
    settle();
    checks++; if (occupancy !== CW'(10)) begin errors++; $display("FAIL wr_rd_after occ=%0d exp=10", occupancy); end
    advance();
  endtask

  task automatic test_lock();
    pulse_reset();
    req_valid = 4'b0011; req_atomic = 4'b0001;
    settle();
    checks++; if (req_grant !== 4'b0001 || arb_locked !== 1'b0) begin errors++; $display("FAIL lock_first grant=%b lock=%b", req_grant, arb_locked); end
    advance();
    req_valid = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      settle();
      checks++; if (req_grant !== '0 || arb_locked !== 1'b1) begin errors++; $display("FAIL lock_hold cyc=%0d grant=%b lock=%b exp 0000/1", i, req_grant, arb_locked); end
      advance();
    end
    req_valid = 4'b0011; req_atomic = 4'b0011;
    settle();
    checks++; if (req_grant !== 4'b0001 || arb_locked !== 1'b1) begin errors++; $display("FAIL lock_second grant=%b lock=%b exp 0001/1", req_grant, arb_locked); end
    advance();
    req_atomic = '0;
    settle();
    checks++; if (req_grant !== 4'b0010 || arb_locked !== 1'b0) begin errors++; $display("FAIL lock_release grant=%b lock=%b exp 0010/0", req_grant, arb_locked); end
    advance();
    req_valid = '0;
  endtask

  task automatic test_reset_locked();
    pulse_reset();
    req_valid = 4'b0001; req_atomic = '0;
    for (int i = 0; i < 6; i++) begin settle(); advance(); end
    req_valid = 4'b0010; req_atomic = 4'b0010;
    settle();
    checks++; if (req_grant !== 4'b0010) begin errors++; $display("FAIL rl_atom grant=%b exp=0010", req_grant); end
    advance();
    req_valid = '0;
    settle();
    checks++; if (arb_locked !== 1'b1 || occupancy !== CW'(7)) begin errors++; $display("FAIL rl_locked lock=%b occ=%0d exp 1/7", arb_locked, occupancy); end
    advance();
    aclr = 1'b1; req_valid = '1;
    settle();
    checks++; if (req_grant !== '0) begin errors++; $display("FAIL rl_aclr grant=%b exp=0000", req_grant); end
    advance();
    aclr = 1'b0; req_atomic = '0;
    settle();
    checks++; if (occupancy !== '0 || arb_locked !== 1'b0 || req_grant !== 4'b0001) begin errors++; $display("FAIL rl_after occ=%0d lock=%b grant=%b exp 0/0/0001", occupancy, arb_locked, req_grant); end
    advance();
    req_valid = '0;
  endtask

  task automatic test_four();
    int ord [6] = '{0, 1, 2, 2, 3, 0};
    pulse_reset();
    req_valid = 4'b1111; req_atomic = 4'b0100;
    for (int i = 0; i < 6; i++) begin
      rnd_all_data();
      settle();
      checks++; if (req_grant !== 4'(1 << ord[i])) begin errors++; $display("FAIL four_grant cyc=%0d got=%b exp_req=%0d", i, req_grant, ord[i]); end
      checks++; if (fifo_data !== req_data[ord[i]*DW +: DW]) begin errors++; $display("FAIL four_data cyc=%0d got=%h", i, fifo_data); end
      advance();
    end
    req_valid = '0; req_atomic = '0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      aclr = ($urandom_range(0, 79) == 0);
      req_valid = 4'($urandom);
      req_atomic = 4'($urandom) & 4'($urandom);
      fifo_rdreq = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      rnd_all_data();
      settle();
      checks++; if (req_grant !== e_grant || fifo_wrreq !== (|e_grant)) begin errors++; $display("FAIL rnd_grant cyc=%0d got=%b/%b exp=%b", i, req_grant, fifo_wrreq, e_grant); end
      checks++; if (fifo_data !== e_data) begin errors++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", i, fifo_data, e_data); end
      checks++; if (occupancy !== CW'(m_occ) || arb_locked !== m_lock) begin errors++; $display("FAIL rnd_state cyc=%0d occ=%0d lock=%b exp %0d/%b", i, occupancy, arb_locked, m_occ, m_lock); end
      advance();
    end
    aclr = 1'b0; req_valid = '0; fifo_rdreq = 1'b0;
  endtask

  initial begin
    aclr = 1'b1; req_valid = '0; req_atomic = '0; fifo_rdreq = 1'b0; req_data = '0;
    test_reset();
    test_alternate();
    test_full_atomic();
    test_full_read();
    test_lock();
    test_reset_locked();
    test_four();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
